hex_key_entry: RTL

- Input-side counterpart of the 32-bit seven-segment display path. The operator keys a 32-bit hex word one nibble at a time, using 4 slide switches and three push-buttons (PUSH, BACK, ENTER).
- Raw buttons are synchronised and debounced. Each press is turned into a one-cycle event, and the nibbles are assembled into a word.
- The committed word is offered to the CPU (e.g. register write or memory poke) over a valid/ready handshake.
- o_entry carries the in-progress word, so the display decoder can show it live.

---
 rtl/hex_key_entry_pkg.sv | 23 ++
 rtl/key_debouncer.sv | 47 ++++
 rtl/hex_key_entry.sv | 89 ++++++++
 3 files changed

// File: rtl/hex_key_entry_pkg.sv
// Shared types, widths and helpers for the hex key entry block.
package hex_key_entry_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned CNT_W      = 4;

    // Raw and debounced key level when the button is not pressed
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic {
        S_ENTRY,
        S_HOLD
    } state_t;

    // Shift a new nibble in at the low end of the word
    function automatic logic [WORD_W-1:0] push_nibble(input logic [WORD_W-1:0]   word,
                                                      input logic [NIBBLE_W-1:0] nib);
        return {word[WORD_W-NIBBLE_W-1:0], nib};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises an active-low raw button, debounces it and emits one pulse per press.
module key_debouncer
    import hex_key_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync;
    logic            level;
    logic [DB_W-1:0] db_cnt;

    // Two-flop synchroniser, stability counter and press pulse on the accepted falling level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta <= KEY_RELEASED;
            sync      <= KEY_RELEASED;
            level     <= KEY_RELEASED;
            db_cnt    <= '0;
            o_press   <= 1'b0;
        end else begin
            sync_meta <= i_key_n;
            sync      <= sync_meta;
            o_press   <= 1'b0;
            if (sync != level) begin
                if (db_cnt == DB_LAST) begin
                    level   <= sync;
                    db_cnt  <= '0;
                    o_press <= (sync != KEY_RELEASED);
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hex_key_entry.sv
// Nibble-by-nibble hex word entry from switches and buttons, committed over valid/ready.
module hex_key_entry
    import hex_key_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned NUM_DIGITS      = MAX_DIGITS
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NIBBLE_W-1:0] i_sw,
    input  logic                i_key_push,
    input  logic                i_key_back,
    input  logic                i_key_enter,
    output logic [WORD_W-1:0]   o_entry,
    output logic [CNT_W-1:0]    o_digit_cnt,
    output logic [WORD_W-1:0]   o_value,
    output logic                o_valid,
    input  logic                i_ready
);

    localparam logic [CNT_W-1:0] DIGITS_FULL = CNT_W'(NUM_DIGITS);

    logic   press_push;
    logic   press_back;
    logic   press_enter;
    state_t state;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_push (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_push),
        .o_press (press_push)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_back),
        .o_press (press_back)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_enter),
        .o_press (press_enter)
    );

    // Entry/hold FSM: edits the word from key events (ENTER > BACK > PUSH), then holds until accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_ENTRY;
            o_entry     <= '0;
            o_digit_cnt <= '0;
            o_value     <= '0;
            o_valid     <= 1'b0;
        end else begin
            case (state)
                S_ENTRY: begin
                    if (press_enter) begin
                        o_value <= o_entry;
                        o_valid <= 1'b1;
                        state   <= S_HOLD;
                    end else if (press_back) begin
                        if (o_digit_cnt != '0) begin
                            o_entry     <= o_entry >> NIBBLE_W;
                            o_digit_cnt <= o_digit_cnt - CNT_W'(1);
                        end
                    end else if (press_push) begin
                        if (o_digit_cnt < DIGITS_FULL) begin
                            o_entry     <= push_nibble(o_entry, i_sw);
                            o_digit_cnt <= o_digit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (o_valid && i_ready) begin
                        o_valid     <= 1'b0;
                        o_entry     <= '0;
                        o_digit_cnt <= '0;
                        state       <= S_ENTRY;
                    end
                end
                default: state <= S_ENTRY;
            endcase
        end
    end

endmodule
